servive_btn_rst_ctrl: RTL

//  Consumes the synchronized reset and button produced by the servive clock

---
 rtl/servive_btn_rst_ctrl_pkg.sv | 17 +
 rtl/servive_rst_stretch.sv | 34 +++
 rtl/servive_btn_rst_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/servive_btn_rst_ctrl_pkg.sv
// Shared FSM encoding and counter-width helper for the servive button/reset controller.
package servive_btn_rst_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DB_PRESS = 3'd1,
    ST_HELD     = 3'd2,
    ST_DB_REL   = 3'd3,
    ST_LOCKOUT  = 3'd4
  } btn_state_t;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/servive_rst_stretch.sv
// Holds o_rst for HOLD edges after the last trigger; any trigger reloads the count.
module servive_rst_stretch
  import servive_btn_rst_ctrl_pkg::*;
#(
  parameter int HOLD = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_trig,
  output logic o_rst
);

  localparam int W = cnt_width(HOLD);
  localparam logic [W-1:0] HOLD_V = W'(HOLD);
  localparam logic [W-1:0] ONE    = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt   <= HOLD_V;
      o_rst <= 1'b1;
    end else if (i_trig) begin
      cnt   <= HOLD_V;
      o_rst <= 1'b1;
    end else if (cnt != '0) begin
      cnt   <= cnt - ONE;
      o_rst <= (cnt != ONE);
    end else begin
      o_rst <= 1'b0;
    end
  end

endmodule

// File: rtl/servive_btn_rst_ctrl.sv
// Button debounce with press/release/long-press events and stretched system reset,
// running in the divided clock domain.
module servive_btn_rst_ctrl
  import servive_btn_rst_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 32,
  parameter int RST_HOLD_CYCLES   = 16,
  parameter bit LONG_RESET        = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rst,
  output logic o_btn,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int LP_W = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_ONE  = LP_W'(1);

  btn_state_t      state;
  logic [DB_W-1:0] db_cnt;
  logic [LP_W-1:0] long_cnt;
  logic            long_done;
  logic            long_trig;
  logic            freeze;

  assign long_trig = LONG_RESET && o_long;
  assign freeze    = o_rst || long_trig;

  servive_rst_stretch #(
    .HOLD(RST_HOLD_CYCLES)
  ) u_rst_stretch (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_trig(long_trig),
    .o_rst (o_rst)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      db_cnt    <= '0;
      long_cnt  <= '0;
      long_done <= 1'b0;
      o_btn     <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      if (freeze) begin
        // No events while reset is held; the state tracks the button so that a
        // button still held on the releasing edge lands directly in LOCKOUT.
        state     <= i_btn ? ST_LOCKOUT : ST_IDLE;
        db_cnt    <= '0;
        long_cnt  <= '0;
        long_done <= 1'b0;
        o_btn     <= 1'b0;
      end else begin
        if ((state == ST_HELD || state == ST_DB_REL) && long_cnt != LP_LAST)
          long_cnt <= long_cnt + LP_ONE;
        case (state)
          ST_IDLE: begin
            if (i_btn) begin
              state  <= ST_DB_PRESS;
              db_cnt <= DB_ONE;
            end
          end
          ST_DB_PRESS: begin
            if (!i_btn) begin
              state  <= ST_IDLE;
              db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
              state     <= ST_HELD;
              o_press   <= 1'b1;
              o_btn     <= 1'b1;
              long_cnt  <= '0;
              long_done <= 1'b0;
            end else begin
              db_cnt <= db_cnt + DB_ONE;
            end
          end
          ST_HELD: begin
            if (long_cnt == LP_LAST && !long_done) begin
              o_long    <= 1'b1;
              long_done <= 1'b1;
            end
            if (!i_btn) begin
              state  <= ST_DB_REL;
              db_cnt <= DB_ONE;
            end
          end
          ST_DB_REL: begin
            if (i_btn) begin
              state <= ST_HELD;
            end else if (db_cnt == DB_LAST) begin
              state     <= ST_IDLE;
              db_cnt    <= '0;
              o_release <= 1'b1;
              o_btn     <= 1'b0;
            end else begin
              db_cnt <= db_cnt + DB_ONE;
            end
          end
          ST_LOCKOUT: begin
            if (i_btn) begin
              db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
              state  <= ST_IDLE;
              db_cnt <= '0;
            end else begin
              db_cnt <= db_cnt + DB_ONE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
